// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer (rotation mode) with its combinational
// rotation stage. One angle in, ITER iterations, cos/sin out through a
// valid/ready handshake.
// Optional feature macro: CORDIC_CLKEN_EN adds a clk_en input that gates
// every register update (reset still acts regardless of clk_en).

// One CORDIC micro-rotation: rotate toward theta by +/- atan(2^-i).
module engine #(
    parameter int WIDTH = 24
) (
    input  logic [4:0]       i,
    input  logic [WIDTH+1:0] x_i,
    input  logic [WIDTH+1:0] y_i,
    input  logic [WIDTH+1:0] w_i,
    input  logic [WIDTH+1:0] theta,
    input  logic [WIDTH+1:0] a_i,
    output logic [WIDTH+1:0] x_o,
    output logic [WIDTH+1:0] y_o,
    output logic [WIDTH+1:0] w_o
);
    logic [WIDTH+1:0] xs, ys;

    // Shift-and-add rotation; direction chosen by accumulated angle vs target.
    always_comb begin
        xs = $signed(x_i) >>> i;
        ys = $signed(y_i) >>> i;
        if ($signed(w_i) < $signed(theta)) begin
            x_o = x_i - ys;
            y_o = y_i + xs;
            w_o = w_i + a_i;
        end else begin
            x_o = x_i + ys;
            y_o = y_i - xs;
            w_o = w_i - a_i;
        end
    end
endmodule

module cordic_iter_ctrl #(
    parameter int WIDTH = 24,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CORDIC_CLKEN_EN
    input  logic             clk_en,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH+1:0] theta_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] cos_o,
    output logic [WIDTH+1:0] sin_o,
    output logic             busy
);
    localparam int DW = WIDTH + 2;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    // Constants are tabulated at 2^24 scale and rescaled to WIDTH; exact for WIDTH=24.
    localparam logic [DW-1:0] K_INIT = DW'((58'd10188014 << WIDTH) >> 24);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [4:0]     i_q, i_d;
    logic [DW-1:0]  x_q, x_d, y_q, y_d, w_q, w_d, th_q, th_d;
    logic [DW-1:0]  cos_q, cos_d, sin_q, sin_d;
    logic [DW-1:0]  eng_x, eng_y, eng_w, a_rom;
    logic           en;

`ifdef CORDIC_CLKEN_EN
    assign en = clk_en;
`else
    assign en = 1'b1;
`endif

    // round(atan(2^-k) * 2^24); beyond k=9 the value is exactly 2^(24-k).
    function automatic logic [DW-1:0] atan_rom(input logic [4:0] k);
        logic [57:0] v;
        case (k)
            5'd0:    v = 58'd13176795;
            5'd1:    v = 58'd7778716;
            5'd2:    v = 58'd4110060;
            5'd3:    v = 58'd2086331;
            5'd4:    v = 58'd1047214;
            5'd5:    v = 58'd524117;
            5'd6:    v = 58'd262123;
            5'd7:    v = 58'd131069;
            5'd8:    v = 58'd65536;
            5'd9:    v = 58'd32768;
            default: v = (k < 5'd24) ? (58'd1 << (5'd24 - k)) : 58'd0;
        endcase
        return DW'((v << WIDTH) >> 24);
    endfunction

    assign a_rom = atan_rom(i_q);

    engine #(.WIDTH(WIDTH)) u_engine (
        .i     (i_q),
        .x_i   (x_q),
        .y_i   (y_q),
        .w_i   (w_q),
        .theta (th_q),
        .a_i   (a_rom),
        .x_o   (eng_x),
        .y_o   (eng_y),
        .w_o   (eng_w)
    );

    // Next-state and datapath control; results latch to outputs only on RUN->DONE.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        th_d    = th_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = K_INIT;
                    y_d     = '0;
                    w_d     = '0;
                    th_d    = theta_i;
                    i_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = eng_x;
                y_d = eng_y;
                w_d = eng_w;
                i_d = i_q + 5'd1;
                if (i_q == LAST) begin
                    cos_d   = eng_x;
                    sin_d   = eng_y;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset overrides clock enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            th_q    <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else if (en) begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            th_q    <= th_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign cos_o     = cos_q;
    assign sin_o     = sin_q;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl (WIDTH=24, ITER=16).
module tb_cordic_iter_ctrl;
    localparam int DW  = 26;
    localparam int TOL = 512;

    logic          clk = 1'b0;
    logic          reset, in_valid, out_ready;
    logic          in_ready, out_valid, busy;
    logic [DW-1:0] theta_i, cos_o, sin_o;
`ifdef CORDIC_CLKEN_EN
    logic          clk_en;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        string nm;
        int    c;
        int    s;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic ov_prev = 1'b0;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.WIDTH(24), .ITER(16)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CORDIC_CLKEN_EN
        .clk_en    (clk_en),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .theta_i   (theta_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_o     (cos_o),
        .sin_o     (sin_o),
        .busy      (busy)
    );

    task automatic chk(input string nm, input int act, input int req, input int tol);
        int d;
        tests++;
        d = act - req;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d tol=%0d", nm, act, req, tol);
        end
    endtask

    // Monitor: on each new result, pop the expected pair and compare.
    always @(negedge clk) begin
        if (out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result actual=cos %0d sin %0d required=none",
                         $signed(cos_o), $signed(sin_o));
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.nm, "_cos"}, int'($signed(cos_o)), mon_e.c, TOL);
                chk({mon_e.nm, "_sin"}, int'($signed(sin_o)), mon_e.s, TOL);
            end
        end
        ov_prev <= out_valid;
    end

    task automatic accept(input int th);
        @(negedge clk);
        in_valid = 1'b1;
        theta_i  = DW'(th);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid after acceptance, checking latency and in_ready low.
    task automatic wait_result(input string nm, input int lat);
        int n;
        int rdy_bad;
        n = 0;
        rdy_bad = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (in_ready) rdy_bad = 1;
        end
        chk({nm, "_latency"}, n, lat, 0);
        chk({nm, "_in_ready_low"}, rdy_bad, 0, 0);
    endtask

    task automatic run_angle(input string nm, input int th, input int ec, input int es);
        sb.push_back('{nm, ec, es});
        accept(th);
        wait_result(nm, 16);
    endtask

    task automatic release_result(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({nm, "_idle_after_ready"}, int'(in_ready), 1, 0);
    endtask

    initial begin
        int c0, s0, bad;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        theta_i   = '0;
`ifdef CORDIC_CLKEN_EN
        clk_en    = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_cos", int'($signed(cos_o)), 0, 0);
        chk("rst_sin", int'($signed(sin_o)), 0, 0);
        @(negedge clk);
        reset = 1'b0;

        run_angle("zero", 0, 16777216, 0);
        release_result("zero");

        run_angle("pi4", 13176795, 11863283, 11863283);
        release_result("pi4");

        run_angle("mpi4", -13176795, 11863283, -11863283);
        release_result("mpi4");

        // Hold DONE with out_ready low, then release while offering a new angle.
        run_angle("pi2", 26353589, 0, 16777216);
        c0  = int'($signed(cos_o));
        s0  = int'($signed(sin_o));
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (int'($signed(cos_o)) != c0 || int'($signed(sin_o)) != s0 || !out_valid || in_ready)
                bad++;
        end
        chk("hold_stable", bad, 0, 0);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        theta_i   = DW'(13176795);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_in_ready", int'(in_ready), 1, 0);
        chk("release_busy", int'(busy), 0, 0);
        @(posedge clk);
        #1;
        chk("release_not_accepted", int'(busy), 0, 0);

        // Abort mid-run: no result may be presented for this angle.
        accept(13176795);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", int'(out_valid), 0, 0);
        chk("abort_in_ready", int'(in_ready), 1, 0);
        chk("abort_busy", int'(busy), 0, 0);
        chk("abort_cos", int'($signed(cos_o)), 0, 0);
        chk("abort_sin", int'($signed(sin_o)), 0, 0);
        @(negedge clk);
        reset = 1'b0;
        run_angle("after_abort", 13176795, 11863283, 11863283);
        release_result("after_abort");

`ifdef CORDIC_CLKEN_EN
        // Alternate clk_en during RUN: latency doubles, values unchanged.
        sb.push_back('{"clken", 11863283, 11863283});
        accept(13176795);
        clk_en = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clk);
                #1;
                n++;
                clk_en = ~clk_en;
            end
            chk("clken_latency", n, 32, 0);
        end
        clk_en = 1'b1;
        release_result("clken");
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
